// File: rtl/fpadd_share_pkg.sv
// Shared types and constants for the time-shared single-precision adder front end.
package fpadd_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } fsm_e;

   localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
   localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
   localparam int          DEF_NREQ = 4;

endpackage

// File: rtl/fpadd_share_ctrl_if.sv
// Requester-side and response-side handshake bundle of fpadd_share_ctrl.
interface fpadd_share_ctrl_if #(
   parameter int NREQ = fpadd_share_pkg::DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_sum;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum
   );
endinterface

// File: rtl/fpadd_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap at NREQ.
module fpadd_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            any
);
   logic [IDW:0] cand;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      cand   = '0;
      if (en) begin
         // walk from the farthest offset down so the nearest one to ptr wins
         for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NREQ)) cand = cand - (IDW + 1)'(NREQ);
            if (req[cand[IDW-1:0]]) begin
               any    = 1'b1;
               gnt_id = cand[IDW-1:0];
            end
         end
         if (any) gnt[gnt_id] = 1'b1;
      end
   end
endmodule

// File: rtl/pfa32.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with subnormal support; NaN results are the canonical quiet NaN.
module pfa32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);
   logic        a_big;
   logic [31:0] x, y;
   logic [7:0]  ex, ey, dexp;
   logic [26:0] xs, ys, lost, r;
   logic [27:0] s28;
   logic [9:0]  e, shamt;
   logic [4:0]  lz;
   logic        up, x_nan, y_nan;
   logic [24:0] m25;

   always_comb begin
      // x always carries the larger magnitude so alignment only shifts y
      a_big = (a_i[30:0] >= b_i[30:0]);
      x     = a_big ? a_i : b_i;
      y     = a_big ? b_i : a_i;
      ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      dexp  = ex - ey;
      xs    = {(x[30:23] != 8'd0), x[22:0], 3'b000};
      ys    = {(y[30:23] != 8'd0), y[22:0], 3'b000};

      if (dexp >= 8'd27) begin
         lost = ys;
         ys   = '0;
      end else begin
         lost = ys << (8'd27 - dexp);
         ys   = ys >> dexp;
      end
      ys[0] = ys[0] | (|lost);

      e     = {2'b00, ex};
      s28   = '0;
      lz    = '0;
      shamt = '0;
      if (x[31] == y[31]) begin
         s28 = {1'b0, xs} + {1'b0, ys};
         if (s28[27]) begin
            r = {s28[27:2], s28[1] | s28[0]};
            e = e + 10'd1;
         end else begin
            r = s28[26:0];
         end
      end else begin
         r  = xs - ys;
         lz = 5'd27;
         for (int i = 0; i < 27; i++) begin
            if (r[i]) lz = 5'(26 - i);
         end
         // never normalise below the minimum exponent: the result goes subnormal
         shamt = ({5'd0, lz} > e - 10'd1) ? e - 10'd1 : {5'd0, lz};
         r     = r << shamt;
         e     = e - shamt;
      end

      up  = r[2] & (r[3] | r[1] | r[0]);
      m25 = {1'b0, r[26:3]} + {24'd0, up};
      if (m25[24]) begin
         m25 = {1'b0, m25[24:1]};
         e   = e + 10'd1;
      end

      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      if (x_nan || y_nan) begin
         sum_o = 32'h7FC0_0000;
      end else if (x[30:23] == 8'hFF) begin
         sum_o = ((y[30:23] == 8'hFF) && (x[31] != y[31])) ? 32'h7FC0_0000 : x;
      end else if (m25 == 25'd0) begin
         sum_o = {x[31] & y[31], 31'd0};
      end else if (e >= 10'd255) begin
         sum_o = {x[31], 8'hFF, 23'd0};
      end else begin
         sum_o = {x[31], (m25[23] ? e[7:0] : 8'd0), m25[22:0]};
      end
   end
endmodule

// File: rtl/fpadd_share_ctrl.sv
// Shares one pfa32 between NREQ requesters: round-robin grant, latch operands,
// register the sum, return it tagged with the owner's index.
module fpadd_share_ctrl
   import fpadd_share_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   fpadd_share_ctrl_if.slave bus,
   output logic             busy,
   output logic [CNTW-1:0]  op_count
);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_EXEC = EXEC;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]      state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [31:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic [31:0]     a_arr [NREQ];
   logic [31:0]     b_arr [NREQ];
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            gnt_any;
   logic            in_idle;
   logic [31:0]     add_sum;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a[32*gi +: 32];
         assign b_arr[gi] = bus.req_b[32*gi +: 32];
      end
   endgenerate

   assign in_idle = (state_q == ST_IDLE);

   fpadd_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req    (bus.req_valid),
      .ptr    (rr_ptr_q),
      .en     (in_idle),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (gnt_any)
   );

   pfa32 u_add (
      .a_i   (a_q),
      .b_i   (b_q),
      .sum_o (add_sum)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               a_d      = a_arr[gnt_id];
               b_d      = b_arr[gnt_id];
               id_d     = gnt_id;
               // explicit wrap so non-power-of-two NREQ never points at a missing port
               rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            sum_d   = add_sum;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               cnt_d   = cnt_q + CNTW'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         a_q      <= FP_ZERO;
         b_q      <= FP_ZERO;
         sum_q    <= FP_ZERO;
         id_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign busy          = !in_idle;
   assign op_count      = cnt_q;
endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for fpadd_share_ctrl: arbitration order, latency, backpressure,
// mid-operation reset and op_count wrap (CNTW = 4).
module tb_fpadd_share_ctrl;
   localparam int NR = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          busy;
   logic [CW-1:0] op_count;

   fpadd_share_ctrl_if #(.NREQ(NR)) bus ();

   fpadd_share_ctrl #(
      .NREQ (NR),
      .CNTW (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_cnt  = 0;
   logic [31:0] op_a [NR];
   logic [31:0] op_b [NR];
   logic [31:0] op_s [NR];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   function automatic int idx_of(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic offer(input int i, input bit on);
      bus.req_valid[i]      = on;
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Entered at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
   task automatic run_txn(input string tag, input int exp_id, input bit keep, input int stall);
      int g;
      g = -1;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (bus.req_ready != '0) begin
            g = idx_of(bus.req_ready);
            break;
         end
         @(negedge clk);
         #1;
      end
      check({tag, "_gnt"}, 32'(g), 32'(exp_id));
      if (g < 0) return;
      check({tag, "_onehot"}, 32'($onehot(bus.req_ready)), 32'd1);
      @(negedge clk);
      if (!keep) bus.req_valid[g] = 1'b0;
      check({tag, "_exec"}, {30'd0, busy, bus.rsp_valid}, 32'd2);
      @(negedge clk);
      check({tag, "_rspv"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
      check({tag, "_sum"}, bus.rsp_sum, op_s[exp_id]);
      if (stall > 0) begin
         bus.rsp_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_hold_v"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_id"}, 32'(bus.rsp_id), 32'(exp_id));
            check({tag, "_hold_sum"}, bus.rsp_sum, op_s[exp_id]);
            check({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
            check({tag, "_hold_cnt"}, 32'(op_count), 32'(exp_cnt));
         end
         bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      check({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
      check({tag, "_idle"}, {30'd0, busy, bus.rsp_valid}, 32'd0);
      $display("txn %s id=%0d sum=%08h op_count=%0d", tag, bus.rsp_id, bus.rsp_sum, op_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; op_s[0] = 32'h4040_0000;
      op_a[1] = 32'h4F00_0000; op_b[1] = 32'h4F00_0000; op_s[1] = 32'h4F80_0000;
      op_a[2] = 32'h0000_0000; op_b[2] = 32'h3F80_0000; op_s[2] = 32'h3F80_0000;
      op_a[3] = 32'h3E80_0000; op_b[3] = 32'h3E80_0000; op_s[3] = 32'h3F00_0000;

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rspv", 32'(bus.rsp_valid), 32'd0);
      check("rst_cnt", 32'(op_count), 32'd0);
      check("rst_sum", bus.rsp_sum, 32'd0);
      check("rst_id", 32'(bus.rsp_id), 32'd0);
      rst_n = 1'b1;

      // single operation from requester 0
      offer(0, 1'b1);
      run_txn("single", 0, 1'b0, 0);

      // all four at once after reset: grants 0,1,2,3
      do_reset();
      for (int i = 0; i < NR; i++) offer(i, 1'b1);
      for (int i = 0; i < NR; i++) run_txn("all4", i, 1'b0, 0);

      // requesters 1 and 3 continuously valid: must alternate
      offer(1, 1'b1);
      offer(3, 1'b1);
      for (int k = 0; k < 4; k++) run_txn("rr", (k % 2 == 0) ? 1 : 3, 1'b1, 0);
      bus.req_valid = '0;

      // backpressure in RESP with requester 2 waiting
      offer(0, 1'b1);
      offer(2, 1'b1);
      run_txn("bp", 0, 1'b0, 5);
      run_txn("bp_next", 2, 1'b0, 0);

      // reset during EXEC: pointer was 3, operation from requester 3 is discarded
      offer(3, 1'b1);
      #1;
      check("mid_gnt", 32'(bus.req_ready), 32'h8);
      @(negedge clk);
      check("mid_exec_busy", 32'(busy), 32'd1);
      rst_n   = 1'b0;
      exp_cnt = 0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_rspv", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_cnt", 32'(op_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) offer(i, 1'b1);
      check("post_rst_rspv", 32'(bus.rsp_valid), 32'd0);
      run_txn("post_rst", 0, 1'b1, 0);

      // 16 more completions: 17 since reset, 4-bit counter wraps to 1
      for (int k = 0; k < 16; k++) run_txn("wrap", (1 + k) % NR, 1'b1, 0);
      check("wrap_final", 32'(op_count), 32'd1);
      bus.req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
